// File: rtl/ultrasonic_ranger.sv
// Round-robin ultrasonic ranger: triggers each channel in turn, times the echo
// pulse in DIV-cycle steps and reports a saturating distance plus an error flag.
module ultrasonic_ranger #(
    parameter int CH       = 2,
    parameter int W        = 8,
    parameter int DIV      = 2981,
    parameter int MAX_DIST = 99,
    parameter int TRIG_CYC = 500,
    parameter int WAIT_MAX = 1500000,
    parameter int GAP_CYC  = 3000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [CH-1:0]   recieve,
    output logic [CH-1:0]   trig,
    output logic [CH*W-1:0] dis,
    output logic [CH-1:0]   valid,
    output logic [CH-1:0]   err
);

    localparam int CNT_A   = (WAIT_MAX > GAP_CYC) ? WAIT_MAX : GAP_CYC;
    localparam int CNT_TOP = (CNT_A > TRIG_CYC) ? CNT_A : TRIG_CYC;
    localparam int CW      = $clog2(CNT_TOP + 1);
    localparam int PW      = $clog2(DIV + 1);
    localparam int CHW     = (CH > 1) ? $clog2(CH) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_TRIG = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_MEAS = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    logic [CH-1:0]   sync1_q, sync2_q, sync3_q;
    logic [2:0]      state_q, state_d;
    logic [CHW-1:0]  ch_q, ch_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [W-1:0]    dist_q, dist_d;
    logic [CH*W-1:0] dis_q, dis_d;
    logic [CH-1:0]   err_q, err_d;
    logic [CH-1:0]   valid_q, valid_d;

    logic            echoSync, echoPrev, echoRise;
    logic [PW-1:0]   basePresc, stepPresc;
    logic [W-1:0]    baseDist, stepDist;
    logic            stepWrap, stepOver;
    logic            doneStb, doneErr;
    logic [W-1:0]    doneDist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= recieve;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign echoSync = sync2_q[ch_q];
    assign echoPrev = sync3_q[ch_q];
    assign echoRise = echoSync & ~echoPrev;

    // The rising-edge cycle is itself a high cycle, so counting starts from a
    // zero base in WAIT_ECHO and continues from the live counters in MEASURE.
    always_comb begin
        basePresc = (state_q == S_MEAS) ? presc_q : '0;
        baseDist  = (state_q == S_MEAS) ? dist_q : '0;
        stepWrap  = (basePresc == PW'(DIV - 1));
        stepOver  = stepWrap && (baseDist == W'(MAX_DIST));
        stepPresc = stepWrap ? '0 : basePresc + PW'(1);
        stepDist  = stepWrap ? baseDist + W'(1) : baseDist;
    end

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        presc_d  = presc_q;
        dist_d   = dist_q;
        dis_d    = dis_q;
        err_d    = err_q;
        valid_d  = '0;
        doneStb  = 1'b0;
        doneErr  = 1'b0;
        doneDist = '0;

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_TRIG;
                    cnt_d   = '0;
                end
            end
            S_TRIG: begin
                if (cnt_q == CW'(TRIG_CYC - 1)) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT: begin
                if (echoRise) begin
                    state_d = S_MEAS;
                    presc_d = stepPresc;
                    dist_d  = stepDist;
                    if (stepOver) begin
                        doneStb  = 1'b1;
                        doneErr  = 1'b1;
                        doneDist = W'(MAX_DIST);
                    end
                end else if (cnt_q == CW'(WAIT_MAX - 1)) begin
                    doneStb  = 1'b1;
                    doneErr  = 1'b1;
                    doneDist = W'(MAX_DIST);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_MEAS: begin
                if (echoSync) begin
                    presc_d = stepPresc;
                    dist_d  = stepDist;
                    if (stepOver) begin
                        doneStb  = 1'b1;
                        doneErr  = 1'b1;
                        doneDist = W'(MAX_DIST);
                    end
                end else begin
                    doneStb  = 1'b1;
                    doneDist = dist_q;
                end
            end
            S_GAP: begin
                if (cnt_q == CW'(GAP_CYC - 1)) begin
                    ch_d    = (ch_q == CHW'(CH - 1)) ? '0 : ch_q + CHW'(1);
                    state_d = en ? S_TRIG : S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (doneStb) begin
            state_d = S_GAP;
            cnt_d   = '0;
            presc_d = '0;
            dist_d  = '0;
            for (int k = 0; k < CH; k++) begin
                if (ch_q == CHW'(k)) begin
                    dis_d[k*W +: W] = doneDist;
                    err_d[k]        = doneErr;
                    valid_d[k]      = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            cnt_q   <= '0;
            presc_q <= '0;
            dist_q  <= '0;
            dis_q   <= '0;
            err_q   <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            dist_q  <= dist_d;
            dis_q   <= dis_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        trig = '0;
        for (int k = 0; k < CH; k++) begin
            trig[k] = (state_q == S_TRIG) && (ch_q == CHW'(k));
        end
    end

    assign dis   = dis_q;
    assign valid = valid_q;
    assign err   = err_q;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for ultrasonic_ranger with small timing parameters; every
// expected value below is worked out by hand from the cycle behaviour.
module tb_ultrasonic_ranger;

    localparam int CH = 2;
    localparam int W  = 8;

    logic            clk;
    logic            rst;
    logic            en;
    logic [CH-1:0]   recieve;
    logic [CH-1:0]   trig;
    logic [CH*W-1:0] dis;
    logic [CH-1:0]   valid;
    logic [CH-1:0]   err;

    int totalCount = 0;
    int badCount   = 0;
    int n;
    int evCount;
    int trigSeen;
    int validSeen;
    int expTick[5]          = '{402, 430, 458, 486, 514};
    logic [1:0] expValid[5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    logic [7:0] field;

    ultrasonic_ranger #(
        .CH(CH), .W(W), .DIV(4), .MAX_DIST(99), .TRIG_CYC(3),
        .WAIT_MAX(20), .GAP_CYC(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .recieve(recieve),
        .trig(trig),
        .dis(dis),
        .valid(valid),
        .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalCount++;
        if (got !== exp) begin
            badCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [CH-1:0] echo, input int cycles);
        recieve = echo;
        for (int i = 0; i < cycles; i++) tick();
    endtask

    task automatic waitTrigOn(input int limit, output int cnt);
        cnt = 0;
        while (trig == '0 && cnt < limit) begin
            tick();
            cnt++;
        end
    endtask

    task automatic countTrigHigh(output int cnt);
        cnt = 0;
        while (trig != '0 && cnt < 50) begin
            tick();
            cnt++;
        end
    endtask

    task automatic waitValid(input int limit, output int cnt);
        cnt = 0;
        while (valid == '0 && cnt < limit) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        rst     = 1'b1;
        en      = 1'b0;
        recieve = '0;
        #12;
        checkOutput("reset trig", trig, 0);
        checkOutput("reset dis", dis, 0);
        checkOutput("reset valid", valid, 0);
        checkOutput("reset err", err, 0);
        tick();
        rst = 1'b0;
        en  = 1'b1;

        // Channel 0: 40 high cycles with DIV=4 gives 10; echo1 meanwhile is ignored.
        waitTrigOn(10, n);
        checkOutput("first trig latency", n, 1);
        checkOutput("first trig channel", trig, 2'b01);
        countTrigHigh(n);
        checkOutput("trig0 width", n, 3);
        applyStimulus(2'b11, 20);
        applyStimulus(2'b01, 20);
        recieve = '0;
        waitValid(10, n);
        checkOutput("fall to valid latency", n, 3);
        checkOutput("ch0 valid", valid, 2'b01);
        checkOutput("ch0 dis", dis[7:0], 10);
        checkOutput("ch0 err", err[0], 0);
        checkOutput("ch1 dis untouched", dis[15:8], 0);
        tick();
        checkOutput("valid single pulse", valid, 0);

        // Channel 1 with no echo times out after 20 WAIT_ECHO cycles.
        waitTrigOn(20, n);
        checkOutput("ch1 trig", trig, 2'b10);
        countTrigHigh(n);
        checkOutput("trig1 width", n, 3);
        waitValid(40, n);
        checkOutput("ch1 timeout latency", n, 20);
        checkOutput("ch1 timeout valid", valid, 2'b10);
        checkOutput("ch1 timeout dis", dis[15:8], 99);
        checkOutput("ch1 timeout err", err[1], 1);
        checkOutput("ch0 dis held", dis[7:0], 10);
        checkOutput("ch0 err held", err[0], 0);
        waitTrigOn(20, n);
        checkOutput("wrap to ch0", trig, 2'b01);

        // Echo0 held for 500 cycles: overflow at 400, then level-high echo
        // on the next ch0 turn must time out rather than measure.
        countTrigHigh(n);
        checkOutput("trig0 width again", n, 3);
        recieve = 2'b01;
        evCount = 0;
        for (int i = 1; i <= 520; i++) begin
            tick();
            if (valid != '0) begin
                if (evCount < 5) begin
                    field = expValid[evCount][0] ? dis[7:0] : dis[15:8];
                    checkOutput("event tick", i, expTick[evCount]);
                    checkOutput("event channel", valid, expValid[evCount]);
                    checkOutput("event err", err & valid, expValid[evCount]);
                    checkOutput("event dis", field, 99);
                end
                evCount++;
            end
            if (i == 500) recieve = '0;
        end
        checkOutput("event count", evCount, 5);

        // Reset in the middle of a channel-1 measurement.
        n = 0;
        while (trig == '0 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("ch1 trig before reset", trig, 2'b10);
        countTrigHigh(n);
        applyStimulus(2'b10, 10);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid reset trig", trig, 0);
        checkOutput("mid reset dis", dis, 0);
        checkOutput("mid reset valid", valid, 0);
        checkOutput("mid reset err", err, 0);
        recieve = '0;
        tick();
        tick();
        rst = 1'b0;
        waitTrigOn(10, n);
        checkOutput("post reset trig latency", n, 1);
        checkOutput("post reset trig channel", trig, 2'b01);

        // Dropping en mid-measurement still completes it, then the FSM idles.
        countTrigHigh(n);
        checkOutput("trig0 width post reset", n, 3);
        applyStimulus(2'b01, 5);
        en = 1'b0;
        applyStimulus(2'b01, 19);
        recieve = '0;
        waitValid(10, n);
        checkOutput("en-drop latency", n, 3);
        checkOutput("en-drop valid", valid, 2'b01);
        checkOutput("en-drop dis", dis[7:0], 6);
        checkOutput("en-drop err", err[0], 0);
        trigSeen  = 0;
        validSeen = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (trig != '0) trigSeen++;
            if (valid != '0) validSeen++;
        end
        checkOutput("idle no trig", trigSeen, 0);
        checkOutput("idle no valid", validSeen, 0);

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
